// File: rtl/complex_fu_pkg.sv
// Shared types and constants for the Complex ALU writeback pipeline.
// Default field widths, the Complex ALU flag bit layout and the writeback packet record.
package complex_fu_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int FLAGS_W_DEF = 6;
    localparam int PTAG_W_DEF  = 7;
    localparam int ALID_W_DEF  = 7;

    // Complex ALU flags layout
    localparam int FLAG_EXECUTED   = 0;
    localparam int FLAG_EXCEPTION  = 1;
    localparam int FLAG_MISPREDICT = 2;
    localparam int FLAG_OVERFLOW   = 3;
    localparam int FLAG_ZERO       = 4;
    localparam int FLAG_NEGATIVE   = 5;

    typedef struct packed {
        logic [DATA_W_DEF-1:0]  result;
        logic [FLAGS_W_DEF-1:0] flags;
        logic [PTAG_W_DEF-1:0]  ptag;
        logic [ALID_W_DEF-1:0]  alid;
    } wb_pkt_t;

endpackage

// File: rtl/complex_fu_pipe_stage.sv
// One pipeline slot: a valid bit plus a packed writeback packet.
// clear_i kills the slot (data is left as is); load_i captures a new slot content.
module complex_fu_pipe_stage
    import complex_fu_pkg::*;
#(
    parameter int PKT_W = 52
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic             d_valid_i,
    input  logic [PKT_W-1:0] d_pkt_i,
    output logic             valid_o,
    output logic [PKT_W-1:0] pkt_o
);

    logic             valid_d, valid_q;
    logic [PKT_W-1:0] pkt_d, pkt_q;

    // Next slot content: clear beats load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = d_valid_i;
            pkt_d   = d_pkt_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot register with asynchronous reset to an empty, zeroed slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/complex_fu_wb_pipe.sv
// Latency-matching result pipeline behind the Complex ALU with valid/ready output,
// bubble collapsing and flush. Optional feature macro: COMPLEX_WB_WAKEUP_EN adds a
// registered early wakeup (wakeup_valid_o / wakeup_ptag_o).
module complex_fu_wb_pipe
    import complex_fu_pkg::*;
#(
    parameter int DATA_W  = complex_fu_pkg::DATA_W_DEF,
    parameter int FLAGS_W = complex_fu_pkg::FLAGS_W_DEF,
    parameter int PTAG_W  = complex_fu_pkg::PTAG_W_DEF,
    parameter int ALID_W  = complex_fu_pkg::ALID_W_DEF,
    parameter int LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*DATA_W-1:0] in_result_i,
    input  logic [FLAGS_W-1:0]  in_flags_i,
    input  logic [PTAG_W-1:0]   in_ptag_i,
    input  logic [ALID_W-1:0]   in_alid_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_result_o,
    output logic [FLAGS_W-1:0]  out_flags_o,
    output logic [PTAG_W-1:0]   out_ptag_o,
    output logic [ALID_W-1:0]   out_alid_o,
    output logic [3:0]          occupancy_o
`ifdef COMPLEX_WB_WAKEUP_EN
    ,
    output logic                wakeup_valid_o,
    output logic [PTAG_W-1:0]   wakeup_ptag_o
`endif
);

    localparam int PKT_W = DATA_W + FLAGS_W + PTAG_W + ALID_W;

    logic [LATENCY-1:0] valid_s;
    logic [PKT_W-1:0]   pkt_s [LATENCY];
    logic [LATENCY-1:0] adv_s;
    logic [LATENCY-1:0] en_s;
    logic [LATENCY-1:0] stage_in_valid_s;
    logic [PKT_W-1:0]   stage_in_pkt_s [LATENCY];
    logic [PKT_W-1:0]   in_pkt_s;
    logic               accept_s;
    logic               xfer_s;
    logic               unused_upper_s;
    logic [3:0]         occ_d, occ_q;

    // Only the low half of the ALU result is written back.
    assign in_pkt_s       = {in_result_i[DATA_W-1:0], in_flags_i, in_ptag_i, in_alid_i};
    assign unused_upper_s = ^in_result_i[2*DATA_W-1:DATA_W];

    // Advance chain: a slot's content may move on if the output drains or any slot ahead is empty.
    always_comb begin
        logic hole;
        hole               = ~valid_s[LATENCY-1];
        adv_s              = '0;
        adv_s[LATENCY-1]   = out_ready_i | hole;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            hole     = hole | ~valid_s[k+1];
            adv_s[k] = out_ready_i | hole;
        end
        en_s = adv_s | ~valid_s;
    end

    // Slot inputs: stage 0 takes the ALU, every other stage takes its predecessor.
    always_comb begin
        stage_in_valid_s    = '0;
        stage_in_valid_s[0] = in_valid_i;
        stage_in_pkt_s[0]   = in_pkt_s;
        for (int k = 1; k < LATENCY; k++) begin
            stage_in_valid_s[k] = valid_s[k-1];
            stage_in_pkt_s[k]   = pkt_s[k-1];
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        complex_fu_pipe_stage #(
            .PKT_W (PKT_W)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .load_i    (en_s[k]),
            .clear_i   (flush_i),
            .d_valid_i (stage_in_valid_s[k]),
            .d_pkt_i   (stage_in_pkt_s[k]),
            .valid_o   (valid_s[k]),
            .pkt_o     (pkt_s[k])
        );
    end

    assign in_ready_o  = en_s[0];
    assign accept_s    = in_valid_i & en_s[0];
    assign xfer_s      = valid_s[LATENCY-1] & out_ready_i & ~flush_i;
    assign out_valid_o = valid_s[LATENCY-1] & ~flush_i;
    assign {out_result_o, out_flags_o, out_ptag_o, out_alid_o} = pkt_s[LATENCY-1];
    assign occupancy_o = occ_q;

    // Occupancy bookkeeping: count accepts in, output transfers out, zero on flush.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = 4'd0;
        end else begin
            case ({accept_s, xfer_s})
                2'b10:   occ_d = occ_q + 4'd1;
                2'b01:   occ_d = occ_q - 4'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= 4'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef COMPLEX_WB_WAKEUP_EN
    // The wakeup is registered as the entry lands in the penultimate stage, so consumers
    // see it one cycle ahead of writeback when nothing stalls. With a single stage the
    // entry lands directly in the output stage and the pulse coincides with out_valid_o.
    logic              wake_enter_s;
    logic [PTAG_W-1:0] wake_src_ptag_s;
    logic              wake_valid_d, wake_valid_q;
    logic [PTAG_W-1:0] wake_ptag_d, wake_ptag_q;

    if (LATENCY >= 3) begin : g_wake_deep
        assign wake_enter_s    = en_s[LATENCY-2] & valid_s[LATENCY-3];
        assign wake_src_ptag_s = pkt_s[LATENCY-3][ALID_W +: PTAG_W];
    end else begin : g_wake_shallow
        assign wake_enter_s    = accept_s;
        assign wake_src_ptag_s = in_ptag_i;
    end

    // Wakeup pulse generation, suppressed by a flush on the capturing edge.
    always_comb begin
        wake_valid_d = 1'b0;
        wake_ptag_d  = wake_ptag_q;
        if (flush_i) begin
            wake_valid_d = 1'b0;
        end else if (wake_enter_s) begin
            wake_valid_d = 1'b1;
            wake_ptag_d  = wake_src_ptag_s;
        end else begin
            wake_valid_d = 1'b0;
        end
    end

    // Wakeup output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wake_valid_q <= 1'b0;
            wake_ptag_q  <= '0;
        end else begin
            wake_valid_q <= wake_valid_d;
            wake_ptag_q  <= wake_ptag_d;
        end
    end

    assign wakeup_valid_o = wake_valid_q;
    assign wakeup_ptag_o  = wake_ptag_q;
`endif

endmodule

// File: tb/tb_complex_fu_wb_pipe.sv
// Self-checking bench for complex_fu_wb_pipe (LATENCY=3): directed vector table,
// wakeup sequence (when COMPLEX_WB_WAKEUP_EN is defined), randomized traffic against
// a queue-based reference model, and an asynchronous reset in mid-stream.
module tb_complex_fu_wb_pipe;
    import complex_fu_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [63:0] in_result_i = 64'd0;
    logic [5:0]  in_flags_i = 6'd0;
    logic [6:0]  in_ptag_i = 7'd0;
    logic [6:0]  in_alid_i = 7'd0;
    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] out_result_o;
    logic [5:0]  out_flags_o;
    logic [6:0]  out_ptag_o;
    logic [6:0]  out_alid_o;
    logic [3:0]  occupancy_o;
`ifdef COMPLEX_WB_WAKEUP_EN
    logic        wakeup_valid_o;
    logic [6:0]  wakeup_ptag_o;
`endif

    int checks = 0;
    int failures = 0;

    complex_fu_wb_pipe #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_result_i  (in_result_i),
        .in_flags_i   (in_flags_i),
        .in_ptag_i    (in_ptag_i),
        .in_alid_i    (in_alid_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_result_o (out_result_o),
        .out_flags_o  (out_flags_o),
        .out_ptag_o   (out_ptag_o),
        .out_alid_o   (out_alid_o),
        .occupancy_o  (occupancy_o)
`ifdef COMPLEX_WB_WAKEUP_EN
        ,
        .wakeup_valid_o (wakeup_valid_o),
        .wakeup_ptag_o  (wakeup_ptag_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       rdy;
        logic       fl;
        logic [6:0] ptag;
        logic       eov;
        logic [6:0] eptag;
        logic [3:0] eocc;
        logic       eir;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(logic iv, logic rdy, logic fl, logic [6:0] p,
                                 logic eov, logic [6:0] ep, logic [3:0] eocc, logic eir);
        vec_t v;
        v = '{iv, rdy, fl, p, eov, ep, eocc, eir};
        vecs.push_back(v);
    endfunction

    function automatic wb_pkt_t mk_pkt(logic [6:0] p);
        wb_pkt_t k;
        k.result = {8'h5A, 17'd0, p};
        k.flags  = p[5:0];
        k.ptag   = p;
        k.alid   = ~p;
        return k;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(logic iv, logic rdy, logic fl, wb_pkt_t pk, logic [31:0] junk);
        in_valid_i  = iv;
        out_ready_i = rdy;
        flush_i     = fl;
        in_result_i = {junk, pk.result};
        in_flags_i  = pk.flags;
        in_ptag_i   = pk.ptag;
        in_alid_i   = pk.alid;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model: in-flight packets oldest first, with edges spent in the pipe
    wb_pkt_t mq[$];
    int      mage[$];

    initial begin
        wb_pkt_t pk;
        wb_pkt_t hp;
        logic    iv, rdy, fl, m_ir, m_ov;

        // ---------------- reset state ----------------
        apply(1'b0, 1'b0, 1'b0, mk_pkt(7'd0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("reset_occupancy", {60'd0, occupancy_o}, 64'd0);
        chk("reset_out_data", {12'd0, out_result_o, out_flags_o, out_ptag_o, out_alid_o}, 64'd0);
        reset_n = 1'b1;
        next_cycle();

        // ---------------- directed vector table ----------------
        // back-to-back, ptag 1..5, out_ready=1
        addv(1, 1, 0, 7'd1, 0, 7'd0, 4'd0, 1);
        addv(1, 1, 0, 7'd2, 0, 7'd0, 4'd1, 1);
        addv(1, 1, 0, 7'd3, 0, 7'd0, 4'd2, 1);
        addv(1, 1, 0, 7'd4, 1, 7'd1, 4'd3, 1);
        addv(1, 1, 0, 7'd5, 1, 7'd2, 4'd3, 1);
        addv(0, 1, 0, 7'd0, 1, 7'd3, 4'd3, 1);
        addv(0, 1, 0, 7'd0, 1, 7'd4, 4'd2, 1);
        addv(0, 1, 0, 7'd0, 1, 7'd5, 4'd1, 1);
        addv(0, 1, 0, 7'd0, 0, 7'd0, 4'd0, 1);
        // stall 6 cycles with continuous input, then release
        addv(1, 0, 0, 7'd10, 0, 7'd0,  4'd0, 1);
        addv(1, 0, 0, 7'd11, 0, 7'd0,  4'd1, 1);
        addv(1, 0, 0, 7'd12, 0, 7'd0,  4'd2, 1);
        addv(1, 0, 0, 7'd13, 1, 7'd10, 4'd3, 0);
        addv(1, 0, 0, 7'd13, 1, 7'd10, 4'd3, 0);
        addv(1, 0, 0, 7'd13, 1, 7'd10, 4'd3, 0);
        addv(1, 1, 0, 7'd13, 1, 7'd10, 4'd3, 1);
        addv(0, 1, 0, 7'd0,  1, 7'd11, 4'd3, 1);
        addv(0, 1, 0, 7'd0,  1, 7'd12, 4'd2, 1);
        addv(0, 1, 0, 7'd0,  1, 7'd13, 4'd1, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0,  4'd0, 1);
        // bubble collapse: inputs at cycles 0 and 2, out_ready=0 until cycle 6
        addv(1, 0, 0, 7'd20, 0, 7'd0,  4'd0, 1);
        addv(0, 0, 0, 7'd0,  0, 7'd0,  4'd1, 1);
        addv(1, 0, 0, 7'd21, 0, 7'd0,  4'd1, 1);
        addv(0, 0, 0, 7'd0,  1, 7'd20, 4'd2, 1);
        addv(0, 0, 0, 7'd0,  1, 7'd20, 4'd2, 1);
        addv(0, 0, 0, 7'd0,  1, 7'd20, 4'd2, 1);
        addv(0, 1, 0, 7'd0,  1, 7'd20, 4'd2, 1);
        addv(0, 1, 0, 7'd0,  1, 7'd21, 4'd1, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0,  4'd0, 1);
        // flush with 3 valid entries and an input offered in the flush cycle
        addv(1, 0, 0, 7'd30, 0, 7'd0, 4'd0, 1);
        addv(1, 0, 0, 7'd31, 0, 7'd0, 4'd1, 1);
        addv(1, 0, 0, 7'd32, 0, 7'd0, 4'd2, 1);
        addv(1, 1, 1, 7'd33, 0, 7'd0, 4'd3, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0, 4'd0, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0, 4'd0, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0, 4'd0, 1);
        addv(0, 1, 0, 7'd0,  0, 7'd0, 4'd0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].iv, vecs[i].rdy, vecs[i].fl, mk_pkt(vecs[i].ptag), 32'hFFFF_0000 ^ i);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid_o}, {63'd0, vecs[i].eov});
            chk($sformatf("vec%0d_occupancy", i), {60'd0, occupancy_o}, {60'd0, vecs[i].eocc});
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready_o}, {63'd0, vecs[i].eir});
            if (vecs[i].eov) begin
                hp = mk_pkt(vecs[i].eptag);
                chk($sformatf("vec%0d_pkt", i),
                    {12'd0, out_result_o, out_flags_o, out_ptag_o, out_alid_o},
                    {12'd0, hp.result, hp.flags, hp.ptag, hp.alid});
            end
            next_cycle();
        end

`ifdef COMPLEX_WB_WAKEUP_EN
        // ---------------- wakeup: single input ptag 0x2A ----------------
        for (int c = 0; c < 5; c++) begin
            if (c == 0) apply(1'b1, 1'b1, 1'b0, mk_pkt(7'h2A), 32'd0);
            else        apply(1'b0, 1'b1, 1'b0, mk_pkt(7'h00), 32'd0);
            @(negedge clk);
            chk($sformatf("wake_c%0d_valid", c), {63'd0, wakeup_valid_o}, {63'd0, (c == 2)});
            chk($sformatf("wake_c%0d_out_valid", c), {63'd0, out_valid_o}, {63'd0, (c == 3)});
            if (c == 2) chk("wake_ptag", {57'd0, wakeup_ptag_o}, 64'h2A);
            next_cycle();
        end
        // wakeup suppressed by flush on the capturing edge
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      apply(1'b1, 1'b1, 1'b0, mk_pkt(7'h15), 32'd0);
            else if (c == 1) apply(1'b0, 1'b1, 1'b1, mk_pkt(7'h00), 32'd0);
            else             apply(1'b0, 1'b1, 1'b0, mk_pkt(7'h00), 32'd0);
            @(negedge clk);
            chk($sformatf("wakeflush_c%0d_valid", c), {63'd0, wakeup_valid_o}, 64'd0);
            chk($sformatf("wakeflush_c%0d_out_valid", c), {63'd0, out_valid_o}, 64'd0);
            next_cycle();
        end
`endif

        // ---------------- randomized traffic vs. reference model ----------------
        mq.delete();
        mage.delete();
        for (int c = 0; c < 400; c++) begin
            iv  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 24) == 0);
            pk.result = $urandom;
            pk.flags  = 6'($urandom);
            pk.flags[FLAG_EXECUTED] = 1'b1;
            pk.ptag   = 7'($urandom);
            pk.alid   = 7'($urandom);
            apply(iv, rdy, fl, pk, $urandom);

            m_ir = (mq.size() < LAT) || rdy;
            m_ov = (mq.size() > 0) && (mage[0] >= LAT - 1) && !fl;

            @(negedge clk);
            chk($sformatf("rnd%0d_in_ready", c), {63'd0, in_ready_o}, {63'd0, m_ir});
            chk($sformatf("rnd%0d_out_valid", c), {63'd0, out_valid_o}, {63'd0, m_ov});
            chk($sformatf("rnd%0d_occupancy", c), {60'd0, occupancy_o}, 64'(mq.size()));
            if (m_ov) begin
                hp = mq[0];
                chk($sformatf("rnd%0d_pkt", c),
                    {12'd0, out_result_o, out_flags_o, out_ptag_o, out_alid_o},
                    {12'd0, hp.result, hp.flags, hp.ptag, hp.alid});
            end

            if (fl) begin
                mq.delete();
                mage.delete();
            end else begin
                if (m_ov && rdy) begin
                    void'(mq.pop_front());
                    void'(mage.pop_front());
                end
                foreach (mage[j]) mage[j] = mage[j] + 1;
                if (iv && m_ir) begin
                    mq.push_back(pk);
                    mage.push_back(0);
                end
            end
            next_cycle();
        end

        // ---------------- asynchronous reset with 2 entries in flight ----------------
        apply(1'b0, 1'b1, 1'b1, mk_pkt(7'd0), 32'd0);
        next_cycle();
        apply(1'b1, 1'b0, 1'b0, mk_pkt(7'd40), 32'd0);
        next_cycle();
        apply(1'b1, 1'b0, 1'b0, mk_pkt(7'd41), 32'd0);
        next_cycle();
        apply(1'b0, 1'b0, 1'b0, mk_pkt(7'd0), 32'd0);
        next_cycle();
        chk("pre_reset_out_valid", {63'd0, out_valid_o}, 64'd1);
        chk("pre_reset_occupancy", {60'd0, occupancy_o}, 64'd2);
        chk("pre_reset_ptag", {57'd0, out_ptag_o}, 64'd40);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("async_reset_occupancy", {60'd0, occupancy_o}, 64'd0);
        chk("async_reset_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("async_reset_ptag", {57'd0, out_ptag_o}, 64'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
